// File: rtl/riscv_ic_sopc_top_if.sv
// Word-addressed memory bus between the core and a memory macro.
//   addr  : byte address (memory uses bits [AW+1:2])
//   wdata : store data
//   we    : write enable, sampled on the rising clock edge
//   rdata : combinational read data
interface riscv_ic_sopc_top_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/riscv_ic_sopc_top.sv
// riscv_ic_sopc_mem: 2^AW x 32 memory, combinational read, synchronous write.
//   Upper and byte-offset address bits are ignored, so accesses wrap.
// riscv_ic_sopc_top: single-cycle RV32I-subset core with instruction ROM
//   (irom_inst) and data RAM (dram_inst); contents are preloaded externally.
//   clk      : system clock
//   rst      : asynchronous reset, active low
//   pc_o     : current PC
//   halted_o : set once ECALL/EBREAK has executed
module riscv_ic_sopc_mem #(
  parameter int AW = 12
) (
  input logic                 clk,
  riscv_ic_sopc_top_if.slave  bus
);
  logic [31:0] mem [0:(2**AW)-1];
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};
  assign bus.rdata = mem[bus.addr[AW+1:2]];

  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.addr[AW+1:2]] <= bus.wdata;
  end
endmodule

module riscv_ic_sopc_top #(
  parameter int          IROM_AW  = 12,
  parameter int          DRAM_AW  = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  output logic        halted_o
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  riscv_ic_sopc_top_if ibus ();
  riscv_ic_sopc_top_if dbus ();

  riscv_ic_sopc_mem #(.AW(IROM_AW)) irom_inst (.clk(clk), .bus(ibus));
  riscv_ic_sopc_mem #(.AW(DRAM_AW)) dram_inst (.clk(clk), .bus(dbus));

  logic [31:0] pc;
  logic        halted;
  logic [31:0] regs [0:31];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1v, rs2v, alu_b, alu_y;
  logic [4:0]  shamt;
  logic        take;
  logic [31:0] next_pc, rd_val;
  logic        rd_we, st_en, halt_now;

  assign ibus.addr  = pc;
  assign ibus.wdata = '0;
  assign ibus.we    = 1'b0;
  assign instr      = ibus.rdata;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is never written, but the read is masked too so it cannot leak
  assign rs1v = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2v = (rs2 == 5'd0) ? '0 : regs[rs2];

  assign alu_b = (opcode == OPC_OP) ? rs2v : imm_i;
  assign shamt = alu_b[4:0];

  // Shared ALU for OP and OP-IMM; instr[30] selects SUB only for OP,
  // since for ADDI that bit is part of the immediate.
  always_comb begin
    alu_y = '0;
    case (f3)
      3'b000: alu_y = (opcode == OPC_OP && instr[30]) ? rs1v - alu_b : rs1v + alu_b;
      3'b001: alu_y = rs1v << shamt;
      3'b010: alu_y = {31'b0, $signed(rs1v) < $signed(alu_b)};
      3'b011: alu_y = {31'b0, rs1v < alu_b};
      3'b100: alu_y = rs1v ^ alu_b;
      3'b101: alu_y = instr[30] ? $unsigned($signed(rs1v) >>> shamt) : rs1v >> shamt;
      3'b110: alu_y = rs1v | alu_b;
      default: alu_y = rs1v & alu_b;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (f3)
      3'b000: take = (rs1v == rs2v);
      3'b001: take = (rs1v != rs2v);
      3'b100: take = ($signed(rs1v) <  $signed(rs2v));
      3'b101: take = ($signed(rs1v) >= $signed(rs2v));
      3'b110: take = (rs1v <  rs2v);
      3'b111: take = (rs1v >= rs2v);
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    next_pc  = pc + 32'd4;
    rd_we    = 1'b0;
    rd_val   = '0;
    st_en    = 1'b0;
    halt_now = 1'b0;
    case (opcode)
      OPC_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
      OPC_AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm_u; end
      OPC_JAL:    begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = pc + imm_j; end
      OPC_JALR:   begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = (rs1v + imm_i) & ~32'd1; end
      OPC_BRANCH: if (take) next_pc = pc + imm_b;
      OPC_LOAD:   if (f3 == 3'b010) begin rd_we = 1'b1; rd_val = dbus.rdata; end
      OPC_STORE:  st_en = (f3 == 3'b010);
      OPC_OPIMM,
      OPC_OP:     begin rd_we = 1'b1; rd_val = alu_y; end
      OPC_SYSTEM: begin halt_now = 1'b1; next_pc = pc; end
      default:    ;
    endcase
    if (halted) begin
      next_pc  = pc;
      rd_we    = 1'b0;
      st_en    = 1'b0;
      halt_now = 1'b0;
    end
  end

  assign dbus.addr  = rs1v + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign dbus.wdata = rs2v;
  // Gated by rst so an edge arriving while reset is asserted never writes RAM
  assign dbus.we    = st_en & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (halt_now) halted <= 1'b1;
      if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
    end
  end

  assign pc_o     = pc;
  assign halted_o = halted;
endmodule

// File: tb/tb_riscv_ic_sopc_top.sv
module tb_riscv_ic_sopc_top;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_o;
  logic        halted_o;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  riscv_ic_sopc_top dut (.clk(clk), .rst(rst), .pc_o(pc_o), .halted_o(halted_o));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPR};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], ST};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Same image into ROM and RAM; non-blocking to match the RAM's own write style
  task automatic put(input logic [11:0] a, input logic [31:0] w);
    dut.irom_inst.mem[a] <= w;
    dut.dram_inst.mem[a] <= w;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) put(12'(i), 32'h0);
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int n = 0;
    while (!halted_o && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(halted_o), 32'd1);
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  logic [31:0] acc;
  logic [31:0] exp_pc [0:10];

  initial begin
    // ---------------- reset / fetch + ALU ----------------
    #1 rst = 1'b0;
    clear_img();
    put(12'd0,  enc_i(12'd5,   5'd0, 3'b000, 5'd1, OPI));   // addi x1,x0,5
    put(12'd1,  enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OPI));   // addi x2,x0,-3
    put(12'd2,  enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));    // add  x3,x1,x2
    put(12'd3,  enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4));    // sub  x4,x2,x1
    put(12'd4,  enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd5));    // sltu x5,x1,x2
    put(12'd5,  enc_i(12'h401, 5'd2, 3'b101, 5'd6, OPI));   // srai x6,x2,1
    put(12'd6,  enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd7));    // slt  x7,x2,x1
    put(12'd7,  enc_i(12'h0F0, 5'd2, 3'b111, 5'd8, OPI));   // andi x8,x2,0xf0
    put(12'd8,  enc_i(12'h003, 5'd1, 3'b001, 5'd9, OPI));   // slli x9,x1,3
    put(12'd9,  enc_i(12'h01C, 5'd2, 3'b101, 5'd10, OPI));  // srli x10,x2,28
    put(12'd10, EBREAK);
    @(posedge clk); #1;
    chk("rst pc c1", pc_o, 32'h0);
    chk("rst halted", 32'(halted_o), 32'h0);
    @(posedge clk); #1;
    chk("rst pc c2", pc_o, 32'h0);
    acc = '0;
    for (int i = 1; i < 32; i++) acc |= dut.regs[i];
    chk("rst regs or", acc, 32'h0);
    @(negedge clk); rst = 1'b1; #1;
    chk("fetch pc0", pc_o, 32'h0);
    @(posedge clk); #1; chk("fetch pc4", pc_o, 32'h4);
    @(posedge clk); #1; chk("fetch pc8", pc_o, 32'h8);
    wait_halt("alu halt", 40);
    chk("alu halt pc", pc_o, 32'h28);
    chk("addi x1", dut.regs[1], 32'h5);
    chk("addi neg x2", dut.regs[2], 32'hFFFF_FFFD);
    chk("add x3", dut.regs[3], 32'h2);
    chk("sub x4", dut.regs[4], 32'hFFFF_FFF8);
    chk("sltu x5", dut.regs[5], 32'h1);
    chk("srai x6", dut.regs[6], 32'hFFFF_FFFE);
    chk("slt x7", dut.regs[7], 32'h1);
    chk("andi x8", dut.regs[8], 32'h0000_00F0);
    chk("slli x9", dut.regs[9], 32'h28);
    chk("srli x10", dut.regs[10], 32'hF);

    // ---------------- load / store ----------------
    restart();
    clear_img();
    put(12'd0, {20'h00001, 5'd1, LUI});                     // lui  x1,0x1
    put(12'd1, enc_i(12'h055, 5'd0, 3'b000, 5'd2, OPI));    // addi x2,x0,0x55
    put(12'd2, enc_s(12'h010, 5'd2, 5'd0));                 // sw   x2,16(x0)
    put(12'd3, enc_i(12'h010, 5'd0, 3'b010, 5'd3, LD));     // lw   x3,16(x0)
    put(12'd4, enc_i(12'h013, 5'd0, 3'b010, 5'd4, LD));     // lw   x4,19(x0)
    put(12'd5, enc_s(12'h000, 5'd1, 5'd1));                 // sw   x1,0(x1)
    put(12'd6, {20'h00004, 5'd6, LUI});                     // lui  x6,0x4
    put(12'd7, enc_i(12'h010, 5'd6, 3'b010, 5'd7, LD));     // lw   x7,16(x6) wraps
    put(12'd8, ECALL);
    @(negedge clk); rst = 1'b1;
    wait_halt("ls halt", 40);
    chk("ls halt pc", pc_o, 32'h20);
    chk("lui x1", dut.regs[1], 32'h1000);
    chk("dram mem4", dut.dram_inst.mem[4], 32'h55);
    chk("lw x3", dut.regs[3], 32'h55);
    chk("lw unaligned x4", dut.regs[4], 32'h55);
    chk("dram mem1024", dut.dram_inst.mem[1024], 32'h1000);
    chk("lw wrap x7", dut.regs[7], 32'h55);

    // ---------------- branch / jump / x0 / halt / reset ----------------
    restart();
    clear_img();
    put(12'd0,  enc_i(12'd1, 5'd0, 3'b000, 5'd1, OPI));     // addi x1,x0,1
    put(12'd1,  enc_b(13'd8, 5'd1, 5'd1, 3'b000));          // beq  x1,x1,+8
    put(12'd2,  enc_i(12'h099, 5'd0, 3'b000, 5'd2, OPI));   // skipped
    put(12'd3,  enc_b(13'd8, 5'd1, 5'd1, 3'b001));          // bne  not taken
    put(12'd4,  enc_i(12'd3, 5'd0, 3'b000, 5'd3, OPI));     // addi x3,x0,3
    put(12'd5,  enc_b(13'd8, 5'd1, 5'd2, 3'b100));          // blt  x2,x1,+8
    put(12'd6,  enc_i(12'h044, 5'd0, 3'b000, 5'd4, OPI));   // skipped
    put(12'd7,  enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPI));     // addi x0,x0,7
    put(12'd8,  enc_j(21'd8, 5'd1));                        // jal  x1,+8
    put(12'd9,  enc_j(21'd8, 5'd0));                        // jal  x0,+8
    put(12'd10, enc_i(12'd1, 5'd1, 3'b000, 5'd0, JLR));     // jalr x0,1(x1)
    put(12'd11, 32'h0);                                     // all-zero nop
    put(12'd12, EBREAK);
    exp_pc = '{32'h04, 32'h0C, 32'h10, 32'h14, 32'h1C, 32'h20,
               32'h28, 32'h24, 32'h2C, 32'h30, 32'h30};
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      chk($sformatf("flow pc step%0d", i), pc_o, exp_pc[i]);
    end
    chk("flow halted", 32'(halted_o), 32'h1);
    chk("jal link x1", dut.regs[1], 32'h24);
    chk("beq skip x2", dut.regs[2], 32'h0);
    chk("bne fall x3", dut.regs[3], 32'h3);
    chk("blt skip x4", dut.regs[4], 32'h0);
    chk("x0 zero", dut.regs[0], 32'h0);
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (pc_o !== 32'h30 || halted_o !== 1'b1) acc = acc + 32'd1;
    end
    chk("halt hold 10cyc", acc, 32'h0);

    // mid-cycle asynchronous reset
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async rst pc", pc_o, 32'h0);
    chk("async rst halted", 32'(halted_o), 32'h0);
    chk("async rst x1", dut.regs[1], 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rerun pc4", pc_o, 32'h4);
    wait_halt("rerun halt", 40);
    chk("rerun halt pc", pc_o, 32'h30);
    chk("rerun x1", dut.regs[1], 32'h24);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
